counter_display_gen: RTL and testbench

//  Parametrised event counter with a multiplexed hex 7-segment display driver. The count

---
 rtl/counter_display_gen_if.sv | 35 +++
 rtl/counter_display_gen.sv | 148 ++++++++++++++
 tb/tb_counter_display_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_display_gen_if.sv
// Control/display bundle for counter_display_gen.
// Inputs: switch, trigger, up_down, hold. Outputs: AN, seven, count.
interface counter_display_gen_if #(
    parameter int NDIG = 4
);
    logic                switch;
    logic                trigger;
    logic                up_down;
    logic                hold;
    logic [NDIG-1:0]     AN;
    logic [6:0]          seven;
    logic [4*NDIG-1:0]   count;

    // Stimulus side: drives the controls, observes the display and count.
    modport master (
        output switch,
        output trigger,
        output up_down,
        output hold,
        input  AN,
        input  seven,
        input  count
    );

    // Design side.
    modport slave (
        input  switch,
        input  trigger,
        input  up_down,
        input  hold,
        output AN,
        output seven,
        output count
    );
endinterface

// File: rtl/counter_display_gen.sv
// Event counter (button or periodic tick) with multiplexed hex 7-seg scan.
// Ports: clock, reset (sync, active-high); bus.switch/trigger/up_down/hold in;
//        bus.AN (active-low digit enables), bus.seven {g..a} active-low, bus.count out.
module counter_display_gen #(
    parameter int NDIG       = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int SCAN_DIV   = 50_000,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic                 clock,
    input  logic                 reset,
    counter_display_gen_if.slave bus
);
    localparam int COUNT_W = 4 * NDIG;
    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIG - 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               clean_q, clean_d;
    logic               prev_q, prev_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic [6:0]         seven_q, seven_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               press;
    logic               tick;
    logic               step;
    logic [IDX_W-1:0]   idx_nxt;

    always_comb begin
        sync1_d = bus.trigger;
        sync2_d = sync1_q;
        clean_d = clean_q;
        prev_d  = clean_q;
        deb_d   = '0;
        tick_d  = tick_q;
        scan_d  = scan_q;
        idx_d   = idx_q;
        an_d    = an_q;
        seven_d = seven_q;
        count_d = count_q;
        idx_nxt = '0;

        // Debounce: a run of samples disagreeing with clean is counted;
        // any agreeing sample clears the run.
        if (sync2_q != clean_q) begin
            if (deb_q == DEB_LAST) begin
                clean_d = sync2_q;
            end else begin
                deb_d = deb_q + DEB_W'(1);
            end
        end

        press = clean_q & ~prev_q;

        // Prescaler parked at 0 in button mode so entering auto mode
        // always waits a full period before the first tick.
        tick = bus.switch && (tick_q == TICK_LAST);
        if (!bus.switch || tick) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end

        step = bus.switch ? tick : press;
        if (step && !bus.hold) begin
            count_d = bus.up_down ? count_q + COUNT_W'(1)
                                  : count_q - COUNT_W'(1);
        end

        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            idx_d   = idx_nxt;
            an_d    = ~(NDIG'(1) << idx_nxt);
            seven_d = hex7(count_q[{idx_nxt, 2'b00} +: 4]);
        end else begin
            scan_d = scan_q + SCAN_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            prev_q  <= 1'b0;
            deb_q   <= '0;
            tick_q  <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= ~NDIG'(1);
            seven_q <= 7'b1000000;
            count_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            prev_q  <= prev_d;
            deb_q   <= deb_d;
            tick_q  <= tick_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seven_q <= seven_d;
            count_q <= count_d;
        end
    end

    assign bus.AN    = an_q;
    assign bus.seven = seven_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_counter_display_gen.sv
// Self-checking bench for counter_display_gen: vector table, corner
// sequences and random stimulus against a behavioural model.
module tb_counter_display_gen;
    localparam int NDIG = 4;
    localparam int TDIV = 4;
    localparam int SDIV = 2;
    localparam int DEB  = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sw = 1'b0, trg = 1'b0, ud = 1'b1, hld = 1'b0;

    always #5 clock = ~clock;

    counter_display_gen_if #(.NDIG(NDIG)) bus ();

    assign bus.switch  = sw;
    assign bus.trigger = trg;
    assign bus.up_down = ud;
    assign bus.hold    = hld;

    counter_display_gen #(
        .NDIG(NDIG), .TICK_DIV(TDIV), .SCAN_DIV(SDIV), .DEB_CYCLES(DEB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [15:0] cnt_m = '0;
    logic [3:0]  an_m  = 4'b1110;
    logic [6:0]  sev_m = 7'b1000000;
    bit          clean_m = 0, press_m = 0, t1 = 0, t2 = 0;
    bit          samp [DEB];
    int          run_m = 0;
    int          n_m   = 0;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic int idx_m();
        return (n_m / SDIV) % NDIG;
    endfunction

    // One rising edge of the specified behaviour, using the inputs
    // that were stable before that edge.
    task automatic model_edge();
        logic [15:0] old;
        bit          stp;
        bit          all;
        int          ix;
        if (reset) begin
            cnt_m = '0; an_m = 4'b1110; sev_m = 7'b1000000;
            clean_m = 0; press_m = 0; t1 = 0; t2 = 0;
            for (int i = 0; i < DEB; i++) samp[i] = 0;
            run_m = 0; n_m = 0;
        end else begin
            old = cnt_m;
            if (sw) stp = ((run_m + 1) % TDIV) == 0;
            else    stp = press_m;
            if (stp && !hld) cnt_m = ud ? cnt_m + 16'd1 : cnt_m - 16'd1;
            run_m = sw ? run_m + 1 : 0;
            // Synchronised sample seen now is the raw level two edges ago.
            for (int i = DEB - 1; i > 0; i--) samp[i] = samp[i-1];
            samp[0] = t2;
            t2 = t1;
            t1 = trg;
            all = 1;
            for (int i = 0; i < DEB; i++) if (samp[i] == clean_m) all = 0;
            press_m = 0;
            if (all) begin
                press_m = !clean_m;
                clean_m = !clean_m;
            end
            n_m++;
            if (n_m % SDIV == 0) begin
                ix    = idx_m();
                an_m  = ~(4'b0001 << ix);
                sev_m = hex7(old[4*ix +: 4]);
            end
        end
    endtask

    task automatic check_model();
        n_cmp++;
        if (bus.count !== cnt_m || bus.AN !== an_m || bus.seven !== sev_m) begin
            n_fail++;
            $display("FAIL model t=%0t count=%h/%h AN=%b/%b seven=%b/%b",
                     $time, bus.count, cnt_m, bus.AN, an_m, bus.seven, sev_m);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        bit          rst, s, t, u, h;
        int          cyc;
        logic [15:0] exp;
        bit          disp;
    } vec_t;

    vec_t vt [$];

    logic [3:0] an_exp  [4];
    logic [6:0] sev_exp [4];
    bit         found;
    int         guard;

    initial begin
        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        sev_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

        //           rst s t u h  cyc  exp      disp
        vt.push_back('{1, 0, 0, 1, 0, 2,  16'h0000, 1});
        vt.push_back('{0, 0, 1, 1, 0, 10, 16'h0001, 0});
        vt.push_back('{0, 0, 0, 1, 0, 10, 16'h0001, 0});
        vt.push_back('{0, 0, 1, 1, 0, 2,  16'h0001, 0});
        vt.push_back('{0, 0, 0, 1, 0, 8,  16'h0001, 0});
        vt.push_back('{0, 0, 1, 1, 1, 10, 16'h0001, 0});
        vt.push_back('{0, 0, 0, 1, 0, 10, 16'h0001, 0});
        vt.push_back('{0, 1, 1, 1, 0, 8,  16'h0003, 0});
        vt.push_back('{0, 0, 0, 1, 0, 10, 16'h0003, 0});
        vt.push_back('{1, 0, 0, 1, 0, 2,  16'h0000, 1});
        vt.push_back('{0, 1, 0, 1, 0, 40, 16'h000A, 0});
        vt.push_back('{0, 1, 0, 1, 1, 40, 16'h000A, 0});
        vt.push_back('{1, 0, 0, 0, 0, 2,  16'h0000, 1});
        vt.push_back('{0, 1, 0, 0, 0, 4,  16'hFFFF, 0});
        vt.push_back('{0, 1, 0, 1, 0, 4,  16'h0000, 0});

        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst; sw = vt[i].s; trg = vt[i].t;
            ud = vt[i].u; hld = vt[i].h;
            repeat (vt[i].cyc) cycle();
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vt[i].exp));
            if (vt[i].disp) begin
                chk($sformatf("vec%0d_AN", i), 32'(bus.AN), 32'(4'b1110));
                chk($sformatf("vec%0d_seven", i), 32'(bus.seven),
                    32'(7'b1000000));
            end
        end

        // Press latency: count must step within 7 cycles, then stay.
        reset = 1; sw = 0; trg = 0; ud = 1; hld = 0;
        repeat (2) cycle();
        reset = 0; trg = 1;
        found = 0;
        for (int k = 0; k < 7 && !found; k++) begin
            cycle();
            if (bus.count == 16'h0001) found = 1;
        end
        chk("press_latency", 32'(found), 32'd1);
        repeat (10) cycle();
        chk("press_single", 32'(bus.count), 32'h0001);
        trg = 0;
        repeat (10) cycle();

        // Scan walk with count = 1234.
        reset = 1;
        cycle();
        reset = 0; sw = 1; ud = 1;
        guard = 0;
        while (cnt_m != 16'h1234 && guard < 20000) begin
            cycle();
            guard++;
        end
        hld = 1;
        repeat (8) cycle();
        chk("scan_count", 32'(bus.count), 32'h1234);
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (bus.AN == 4'b1110) found = 1;
            else cycle();
        end
        chk("scan_sync", 32'(found), 32'd1);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("scan%0d_AN", j), 32'(bus.AN), 32'(an_exp[j]));
            chk($sformatf("scan%0d_seven", j), 32'(bus.seven), 32'(sev_exp[j]));
            repeat (2) cycle();
        end

        // Reset mid-count at count=0057, idx=2.
        reset = 1; hld = 0;
        cycle();
        reset = 0; sw = 1; ud = 1;
        guard = 0;
        while (!(cnt_m == 16'h0057 && idx_m() == 2) && guard < 2000) begin
            cycle();
            guard++;
        end
        chk("mid_reached", 32'(bus.count), 32'h0057);
        reset = 1; trg = 1;
        cycle();
        chk("mid_rst_count", 32'(bus.count), 32'h0000);
        chk("mid_rst_AN", 32'(bus.AN), 32'(4'b1110));
        cycle();
        reset = 0; sw = 0;
        repeat (15) cycle();
        chk("held_trig_le1", 32'(bus.count <= 16'h0001), 32'd1);
        trg = 0;
        repeat (8) cycle();

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0)  trg = ~trg;
            if ($urandom_range(0, 59) == 0) sw  = ~sw;
            if ($urandom_range(0, 39) == 0) hld = ~hld;
            if ($urandom_range(0, 29) == 0) ud  = ~ud;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
